// File: rtl/rf_arb_pkg.sv
// Shared types, widths and helpers for the register-file write arbiter.
package rf_arb_pkg;

  localparam int RF_ADDR_W  = 5;
  localparam int RF_DATA_W  = 32;
  localparam int RF_MAX_REQ = 8;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = '0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic [2:0] onehot_to_idx(input logic [RF_MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < RF_MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, scans from ptr+1 modulo N over req & mask.
// Latency: zero cycles. Backpressure: none, pure function of its inputs.
module rr_pick
  import rf_arb_pkg::*;
#(
  parameter int N = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any_grant
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand] && mask[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign idx       = IDX_W'(onehot_to_idx(RF_MAX_REQ'(gnt)));
  assign any_grant = |gnt;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port; address-0 writes are accepted but dropped.
// Latency: accepted in cycle N -> wr/writeAddr/in in cycle N+1. Backpressure: one-hot req_ready, none while hold=1.
// RF_ARB_FIXED_PRI_EN: requester 0 gets strict priority, 1..NUM_REQ-1 round-robin among themselves.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [ADDR_W-1:0]         readAddr1,
  input  logic [ADDR_W-1:0]         readAddr2,
  output logic                      wr,
  output logic [ADDR_W-1:0]         writeAddr,
  output logic [DATA_W-1:0]         in,
  output logic                      hazard1,
  output logic                      hazard2
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef RF_ARB_FIXED_PRI_EN
  localparam logic [NUM_REQ-1:0] PICK_MASK = {{(NUM_REQ-1){1'b1}}, 1'b0};
`else
  localparam logic [NUM_REQ-1:0] PICK_MASK = {NUM_REQ{1'b1}};
`endif

  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [DATA_W-1:0] data_a [NUM_REQ];

  logic [NUM_REQ-1:0] pick_gnt, gnt_sel;
  logic [IDX_W-1:0]   pick_idx, sel_idx;
  logic               pick_any, any_req, accept;

  logic [IDX_W-1:0]  ptr_d, ptr_q;
  logic              wr_d, wr_q;
  logic [ADDR_W-1:0] waddr_d, waddr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
      data_a[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .mask      (PICK_MASK),
    .gnt       (pick_gnt),
    .idx       (pick_idx),
    .any_grant (pick_any)
  );

  always_comb begin
    gnt_sel = pick_gnt;
    sel_idx = pick_idx;
    any_req = pick_any;
`ifdef RF_ARB_FIXED_PRI_EN
    if (req_valid[0]) begin
      gnt_sel = NUM_REQ'(1);
      sel_idx = '0;
      any_req = 1'b1;
    end
`endif
    accept    = any_req & ~hold;
    req_ready = accept ? gnt_sel : '0;
  end

  // Pointer only moves on an accepted transfer; under fixed priority it ignores requester 0.
  always_comb begin
    ptr_d = ptr_q;
`ifdef RF_ARB_FIXED_PRI_EN
    if (accept && (sel_idx != '0)) ptr_d = sel_idx;
`else
    if (accept) ptr_d = sel_idx;
`endif
  end

  always_comb begin
    wr_d    = accept && (addr_a[sel_idx] != ADDR_W'(RF_ZERO_REG));
    waddr_d = wr_d ? addr_a[sel_idx] : waddr_q;
    wdata_d = wr_d ? data_a[sel_idx] : wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wr        = wr_q;
  assign writeAddr = waddr_q;
  assign in        = wdata_q;
  assign hazard1   = wr_q && (waddr_q == readAddr1) && (waddr_q != ADDR_W'(RF_ZERO_REG));
  assign hazard2   = wr_q && (waddr_q == readAddr2) && (waddr_q != ADDR_W'(RF_ZERO_REG));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes go into a queue, a negedge monitor pops and compares.
module tb_regfile_write_arbiter;
  import rf_arb_pkg::*;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              hold = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [AW-1:0]     readAddr1 = '0;
  logic [AW-1:0]     readAddr2 = '0;
  logic              wr;
  logic [AW-1:0]     writeAddr;
  logic [DW-1:0]     in;
  logic              hazard1, hazard2;

  regfile_write_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(rst_n), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .wr(wr), .writeAddr(writeAddr), .in(in),
    .hazard1(hazard1), .hazard2(hazard2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  wr_req_t exp_q[$];

  logic [AW-1:0] addr_tab [NR];
  logic [DW-1:0] data_tab [NR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input int idx);
    wr_req_t e;
    e.addr = addr_tab[idx];
    e.data = data_tab[idx];
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [NR-1:0] v);
    req_valid = v;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = addr_tab[i];
      req_data[i*DW +: DW] = data_tab[i];
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", {27'd0, writeAddr}, 32'hFFFF_FFFF);
      end else begin
        wr_req_t e;
        e = exp_q.pop_front();
        chk("sb_addr", {27'd0, writeAddr}, {27'd0, e.addr});
        chk("sb_data", in, e.data);
      end
    end
  end

  initial begin
    addr_tab[0] = 5'd1; data_tab[0] = 32'hAAAA_0001;
    addr_tab[1] = 5'd2; data_tab[1] = 32'hBBBB_0002;
    addr_tab[2] = 5'd3; data_tab[2] = 32'hCCCC_0003;

    // Reset values, then a write in flight killed by async reset
    #2;
    chk("rst_wr", {31'd0, wr}, 32'd0);
    chk("rst_waddr", {27'd0, writeAddr}, 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    drive(3'b111);
    @(negedge clk);
    chk("t1_first_grant", {29'd0, req_ready}, 32'd1);
    next_cycle();
    chk("t1_wr_inflight", {31'd0, wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_wr_async_clr", {31'd0, wr}, 32'd0);
    chk("t1_waddr_clr", {27'd0, writeAddr}, 32'd0);
    chk("t1_in_clr", in, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Round-robin with all requesters valid
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_rr_grant", {29'd0, req_ready}, 32'd1 << (i % 3));
      push(i % 3);
      if (i >= 1) chk("t2_wr_every_cycle", {31'd0, wr}, 32'd1);
      next_cycle();
    end

    // Address-0 write is accepted but dropped
    addr_tab[1] = 5'd0; data_tab[1] = 32'hFFFF_FFFF;
    drive(3'b010);
    @(negedge clk);
    chk("t3_zero_ready", {29'd0, req_ready}, 32'b010);
    next_cycle();
    addr_tab[2] = 5'd4; data_tab[2] = 32'hDDDD_0004;
    drive(3'b100);
    @(negedge clk);
    chk("t3_zero_wr", {31'd0, wr}, 32'd0);
    chk("t3_next_ready", {29'd0, req_ready}, 32'b100);
    push(2);
    next_cycle();
    drive(3'b000);
    @(negedge clk);
    chk("t3_idle_ready", {29'd0, req_ready}, 32'd0);
    next_cycle();

    // Stall: last grant 1, hold 3 cycles, resume at requester 2
    addr_tab[1] = 5'd2; data_tab[1] = 32'hBBBB_1002;
    addr_tab[2] = 5'd3; data_tab[2] = 32'hCCCC_1003;
    drive(3'b010);
    @(negedge clk);
    chk("t4_pre_grant", {29'd0, req_ready}, 32'b010);
    push(1);
    next_cycle();
    drive(3'b111);
    hold = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("t4_hold_ready", {29'd0, req_ready}, 32'd0);
      if (j >= 1) chk("t4_hold_wr", {31'd0, wr}, 32'd0);
      next_cycle();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("t4_resume_grant", {29'd0, req_ready}, 32'b100);
    push(2);
    next_cycle();
    drive(3'b000);
    @(negedge clk);
    next_cycle();

    // Hazard outputs
    addr_tab[0] = 5'd5; data_tab[0] = 32'hEEEE_0005;
    drive(3'b001);
    readAddr1 = 5'd5;
    readAddr2 = 5'd6;
    @(negedge clk);
    chk("t5_grant", {29'd0, req_ready}, 32'b001);
    chk("t5_haz_unregistered", {31'd0, hazard1}, 32'd0);
    push(0);
    next_cycle();
    drive(3'b000);
    @(negedge clk);
    chk("t5_hazard1", {31'd0, hazard1}, 32'd1);
    chk("t5_hazard2", {31'd0, hazard2}, 32'd0);
    next_cycle();
    addr_tab[0] = 5'd0; data_tab[0] = 32'h1234_5678;
    drive(3'b001);
    readAddr1 = 5'd0;
    @(negedge clk);
    chk("t5_zero_grant", {29'd0, req_ready}, 32'b001);
    next_cycle();
    drive(3'b000);
    @(negedge clk);
    chk("t5_zero_wr", {31'd0, wr}, 32'd0);
    chk("t5_zero_hazard1", {31'd0, hazard1}, 32'd0);
    next_cycle();

    // Requester 0 and 1 contending for 4 cycles after a fresh reset
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    addr_tab[0] = 5'd7; data_tab[0] = 32'h7777_0007;
    addr_tab[1] = 5'd8; data_tab[1] = 32'h8888_0008;
    drive(3'b011);
    for (int i = 0; i < 4; i++) begin
      int g;
`ifdef RF_ARB_FIXED_PRI_EN
      g = 0;
`else
      g = i % 2;
`endif
      @(negedge clk);
      chk("t6_grant", {29'd0, req_ready}, 32'd1 << g);
      push(g);
      next_cycle();
    end
    drive(3'b000);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
